// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, FSM states and operation codes for the calculator sequencer
package calc_pkg;

  localparam logic [4:0] KEY_SUM  = 5'h10;
  localparam logic [4:0] KEY_MULT = 5'h11;
  localparam logic [4:0] KEY_AND  = 5'h12;
  localparam logic [4:0] KEY_EXE  = 5'h13;
  localparam logic [4:0] KEY_SUB  = 5'h14;
  localparam logic [4:0] KEY_OR   = 5'h15;
  localparam logic [4:0] KEY_CE   = 5'h16;
  localparam logic [4:0] KEY_CLR  = 5'h17;

  typedef enum logic [1:0] {S_OP1, S_OP2, S_CALC, S_RES} state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_SUM  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MULT = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5
  } op_e;

  // Operator keys map to an op; every other code maps to OP_NONE.
  function automatic op_e key_to_op(input logic [4:0] k);
    case (k)
      KEY_SUM:  return OP_SUM;
      KEY_SUB:  return OP_SUB;
      KEY_MULT: return OP_MULT;
      KEY_AND:  return OP_AND;
      KEY_OR:   return OP_OR;
      default:  return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - key input and display/status bus between cursor, sequencer and display
interface calc_sequencer_if #(parameter int W = 16);
  logic         key_valid;
  logic [4:0]   key_val;
  logic         dec_mode;
  logic         key_ready;
  logic         restriction;
  logic [W-1:0] display_val;
  logic [2:0]   op_code;
  logic         result_valid;
  logic         err;

  modport master (
    output key_valid, key_val, dec_mode,
    input  key_ready, restriction, display_val, op_code, result_valid, err
  );

  modport slave (
    input  key_valid, key_val, dec_mode,
    output key_ready, restriction, display_val, op_code, result_valid, err
  );
endinterface

// File: rtl/calc_alu.sv
// rtl/calc_alu.sv - combinational A op B with carry/borrow/overflow flag
module calc_alu
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] res,
  output logic         err
);

  logic [W:0]     sum_w;
  logic [2*W-1:0] prod;

  always_comb begin
    sum_w = {1'b0, a} + {1'b0, b};
    prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    res   = '0;
    err   = 1'b0;
    case (op)
      OP_SUM:  begin res = sum_w[W-1:0]; err = sum_w[W];         end
      OP_SUB:  begin res = a - b;        err = (a < b);          end
      OP_MULT: begin res = prod[W-1:0];  err = |prod[2*W-1:W];   end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - operand entry and operation sequencing FSM for the grid-cursor calculator
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W          = 16,
  parameter int MAX_DIGITS = 4
) (
  input logic              clk,
  input logic              rst_n,
  calc_sequencer_if.slave  bus
);

  localparam int            CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  state_e         state_q, state_d;
  op_e            op_q, op_d, next_op_q, next_op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CW-1:0]  cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic           chain_q, chain_d, err_q, err_d;
  logic           restriction_q, restriction_d, result_valid_q, result_valid_d;

  logic [W-1:0]   alu_res, disp;
  logic           alu_err, key_ready, accept, digit_ok;
  logic [3:0]     digit;
  op_e            key_op;

  function automatic logic [W-1:0] push_digit(input logic [W-1:0] x, input logic [3:0] d,
                                              input logic dec);
    if (dec) return x * W'(10) + W'(d);
    return {x[W-5:0], d};
  endfunction

  calc_alu #(.W(W)) u_alu (.a(a_q), .b(b_q), .op(op_q), .res(alu_res), .err(alu_err));

  assign key_ready = (state_q != S_CALC);
  assign accept    = bus.key_valid & key_ready;
  assign digit     = bus.key_val[3:0];
  // Entry mode follows the latched restriction so a mid-operand dec_mode flip cannot mix radices.
  assign digit_ok  = !bus.key_val[4] && (!restriction_q || digit <= 4'd9);
  assign key_op    = key_to_op(bus.key_val);

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    next_op_d      = next_op_q;
    a_d            = a_q;
    b_d            = b_q;
    r_d            = r_q;
    cnt_a_d        = cnt_a_q;
    cnt_b_d        = cnt_b_q;
    chain_d        = chain_q;
    err_d          = err_q;
    restriction_d  = restriction_q;
    result_valid_d = 1'b0;

    case (state_q)
      S_OP1: begin
        if (cnt_a_q == '0) restriction_d = bus.dec_mode;
        if (accept) begin
          if (digit_ok) begin
            if (cnt_a_q < CNT_MAX) begin
              a_d     = push_digit(a_q, digit, restriction_q);
              cnt_a_d = cnt_a_q + 1'b1;
            end
          end else if (key_op != OP_NONE) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_OP2;
          end else if (bus.key_val == KEY_CE) begin
            a_d     = '0;
            cnt_a_d = '0;
          end
        end
      end
      S_OP2: begin
        if (accept) begin
          if (digit_ok) begin
            if (cnt_b_q < CNT_MAX) begin
              b_d     = push_digit(b_q, digit, restriction_q);
              cnt_b_d = cnt_b_q + 1'b1;
            end
          end else if (key_op != OP_NONE) begin
            if (cnt_b_q == '0) begin
              op_d = key_op;
            end else begin
              next_op_d = key_op;
              chain_d   = 1'b1;
              state_d   = S_CALC;
            end
          end else if (bus.key_val == KEY_EXE && cnt_b_q != '0) begin
            chain_d = 1'b0;
            state_d = S_CALC;
          end else if (bus.key_val == KEY_CE) begin
            b_d     = '0;
            cnt_b_d = '0;
          end
        end
      end
      S_CALC: begin
        r_d            = alu_res;
        err_d          = alu_err;
        result_valid_d = 1'b1;
        if (chain_q) begin
          a_d     = alu_res;
          op_d    = next_op_q;
          b_d     = '0;
          cnt_b_d = '0;
          state_d = S_OP2;
        end else begin
          state_d = S_RES;
        end
      end
      default: begin
        if (accept) begin
          if (digit_ok) begin
            a_d     = push_digit('0, digit, restriction_q);
            cnt_a_d = CW'(1);
            op_d    = OP_NONE;
            state_d = S_OP1;
          end else if (key_op != OP_NONE) begin
            a_d     = r_q;
            op_d    = key_op;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_OP2;
          end else if (bus.key_val == KEY_CE) begin
            a_d     = '0;
            cnt_a_d = '0;
            state_d = S_OP1;
          end
        end
      end
    endcase

    if (accept && bus.key_val == KEY_CLR) begin
      state_d        = S_OP1;
      op_d           = OP_NONE;
      next_op_d      = OP_NONE;
      a_d            = '0;
      b_d            = '0;
      r_d            = '0;
      cnt_a_d        = '0;
      cnt_b_d        = '0;
      chain_d        = 1'b0;
      err_d          = 1'b0;
      restriction_d  = 1'b0;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_OP1;
      op_q           <= OP_NONE;
      next_op_q      <= OP_NONE;
      a_q            <= '0;
      b_q            <= '0;
      r_q            <= '0;
      cnt_a_q        <= '0;
      cnt_b_q        <= '0;
      chain_q        <= 1'b0;
      err_q          <= 1'b0;
      restriction_q  <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      next_op_q      <= next_op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      r_q            <= r_d;
      cnt_a_q        <= cnt_a_d;
      cnt_b_q        <= cnt_b_d;
      chain_q        <= chain_d;
      err_q          <= err_d;
      restriction_q  <= restriction_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    case (state_q)
      S_OP1:   disp = a_q;
      S_OP2:   disp = (cnt_b_q != '0) ? b_q : a_q;
      default: disp = r_q;
    endcase
  end

  assign bus.key_ready    = key_ready;
  assign bus.restriction  = restriction_q;
  assign bus.display_val  = disp;
  assign bus.op_code      = op_q;
  assign bus.result_valid = result_valid_q;
  assign bus.err          = err_q;

endmodule
